// File: rtl/pixel_dispatcher_pkg.sv
// Shared types and helpers for the pixel dispatcher.
//   top_state_t  : frame sequencing FSM states
//   slot_state_t : per-engine slot lifecycle
//   coord_t      : (x,y) pixel coordinate at the default widths
//   rr_next      : round-robin pointer advance (granted index + 1, mod n)
package dispatcher_pkg;

    localparam int NUM_ENGINES_D   = 5;
    localparam int SCREEN_WIDTH_D  = 640;
    localparam int SCREEN_HEIGHT_D = 480;
    localparam int XW_D            = 10;
    localparam int YW_D            = 9;
    localparam int DEPTH_W_D       = 10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} top_state_t;
    typedef enum logic [1:0] {FREE, RUN, HOLD} slot_state_t;

    typedef struct packed {
        logic [XW_D-1:0] x;
        logic [YW_D-1:0] y;
    } coord_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pixel_dispatcher_if.sv
// Pixel write port between the dispatcher and the frame buffer writer.
//   pix_valid/pix_ready : valid/ready handshake
//   pix_x/pix_y         : pixel coordinate
//   pix_depth           : depth result for that pixel
// master = dispatcher side, slave = frame buffer writer side.
interface pixel_dispatcher_if #(
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int DEPTH_W = 10
);
    logic               pix_valid;
    logic               pix_ready;
    logic [XW-1:0]      pix_x;
    logic [YW-1:0]      pix_y;
    logic [DEPTH_W-1:0] pix_depth;

    modport master (output pix_valid, pix_x, pix_y, pix_depth, input pix_ready);
    modport slave  (input pix_valid, pix_x, pix_y, pix_depth, output pix_ready);
endinterface

// File: rtl/pixel_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter. Searches req upward from ptr
// (wrapping) and grants the first set bit. The pointer lives in the parent.
//   req       : request vector
//   ptr       : search start index (< N)
//   grant     : one-hot grant
//   grant_idx : index of the granted bit
//   any       : at least one request present
module rr_arbiter #(
    parameter int N  = 5,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);
    always_comb begin : p_arb
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end
endmodule

// File: rtl/pixel_dispatcher.sv
// Frame scheduler sharing a pool of depth engines. Walks (x,y) in raster
// order, dispatches each job to a free engine slot, captures the engine's
// depth result and round-robins results onto one valid/ready pixel port.
//   clk, reset          : clock, async active-high reset
//   frame_start         : request a frame (honoured only in S_IDLE)
//   frame_busy          : frame in progress (S_RUN/S_DRAIN)
//   frame_done          : one-cycle pulse in S_DONE
//   eng_start/x/y       : per-engine start pulse and job coordinate
//   eng_done/eng_depth  : per-engine completion and result
//   pix                 : pixel write port (master)
//   err_spurious        : sticky, eng_done on a slot that was not running
module pixel_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int NUM_ENGINES   = NUM_ENGINES_D,
    parameter int SCREEN_WIDTH  = SCREEN_WIDTH_D,
    parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_D,
    parameter int XW            = XW_D,
    parameter int YW            = YW_D,
    parameter int DEPTH_W       = DEPTH_W_D
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 frame_start,
    output logic                                 frame_busy,
    output logic                                 frame_done,
    output logic [NUM_ENGINES-1:0]               eng_start,
    output logic [NUM_ENGINES-1:0][XW-1:0]       eng_x,
    output logic [NUM_ENGINES-1:0][YW-1:0]       eng_y,
    input  logic [NUM_ENGINES-1:0]               eng_done,
    input  logic [NUM_ENGINES-1:0][DEPTH_W-1:0]  eng_depth,
    pixel_dispatcher_if.master                   pix,
    output logic                                 err_spurious
);
    localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    top_state_t  state, state_nx;
    slot_state_t slot_st [NUM_ENGINES];

    logic [NUM_ENGINES-1:0][DEPTH_W-1:0] slot_depth;
    logic [XW-1:0] jx;
    logic [YW-1:0] jy;
    logic [PW-1:0] disp_ptr, coll_ptr, disp_idx, coll_idx;
    logic [NUM_ENGINES-1:0] free_req, run_req, hold_req, disp_gnt, coll_gnt;
    logic disp_any, coll_any, dispatch, last_job, load_en, load;

    always_comb begin
        free_req = '0;
        run_req  = '0;
        hold_req = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            free_req[i] = (slot_st[i] == FREE);
            run_req[i]  = (slot_st[i] == RUN);
            hold_req[i] = (slot_st[i] == HOLD);
        end
    end

    rr_arbiter #(.N(NUM_ENGINES), .PW(PW)) u_disp_arb (
        .req(free_req), .ptr(disp_ptr), .grant(disp_gnt), .grant_idx(disp_idx), .any(disp_any)
    );

    rr_arbiter #(.N(NUM_ENGINES), .PW(PW)) u_coll_arb (
        .req(hold_req), .ptr(coll_ptr), .grant(coll_gnt), .grant_idx(coll_idx), .any(coll_any)
    );

    assign dispatch = (state == S_RUN) && disp_any;
    assign last_job = (jx == XW'(SCREEN_WIDTH - 1)) && (jy == YW'(SCREEN_HEIGHT - 1));
    // Output register refills when empty or being drained this cycle.
    assign load_en  = !pix.pix_valid || pix.pix_ready;
    assign load     = load_en && coll_any;

    // Frame sequencing FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (frame_start) state_nx = S_RUN;
            S_RUN:   if (dispatch && last_job) state_nx = S_DRAIN;
            S_DRAIN: if ((&free_req) && !pix.pix_valid) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_busy <= (state_nx == S_RUN) || (state_nx == S_DRAIN);
            frame_done <= (state_nx == S_DONE);
        end
    end

    // Job counter, dispatch pointer and start pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jx        <= '0;
            jy        <= '0;
            disp_ptr  <= '0;
            eng_start <= '0;
        end else begin
            eng_start <= dispatch ? disp_gnt : '0;
            if (state == S_IDLE && frame_start) begin
                jx <= '0;
                jy <= '0;
            end else if (dispatch && !last_job) begin
                if (jx == XW'(SCREEN_WIDTH - 1)) begin
                    jx <= '0;
                    jy <= jy + 1'b1;
                end else begin
                    jx <= jx + 1'b1;
                end
            end
            if (dispatch) disp_ptr <= PW'(rr_next(int'(disp_idx), NUM_ENGINES));
        end
    end

    // Slot lifecycle. Each transition depends only on the slot's current
    // state, so dispatch, capture and release never collide on one slot; a
    // slot released this cycle is only seen as FREE from the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENGINES; i++) slot_st[i] <= FREE;
            eng_x        <= '0;
            eng_y        <= '0;
            slot_depth   <= '0;
            err_spurious <= 1'b0;
        end else begin
            err_spurious <= err_spurious | (|(eng_done & ~run_req));
            for (int i = 0; i < NUM_ENGINES; i++) begin
                case (slot_st[i])
                    FREE: if (dispatch && disp_gnt[i]) begin
                        slot_st[i] <= RUN;
                        eng_x[i]   <= jx;
                        eng_y[i]   <= jy;
                    end
                    RUN: if (eng_done[i]) begin
                        slot_st[i]    <= HOLD;
                        slot_depth[i] <= eng_depth[i];
                    end
                    HOLD: if (load && coll_gnt[i]) slot_st[i] <= FREE;
                    default: slot_st[i] <= FREE;
                endcase
            end
        end
    end

    // Single-entry output register; fields only change on a load, so they
    // stay stable under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix.pix_valid <= 1'b0;
            pix.pix_x     <= '0;
            pix.pix_y     <= '0;
            pix.pix_depth <= '0;
            coll_ptr      <= '0;
        end else if (load_en) begin
            pix.pix_valid <= coll_any;
            if (coll_any) begin
                pix.pix_x     <= eng_x[coll_idx];
                pix.pix_y     <= eng_y[coll_idx];
                pix.pix_depth <= slot_depth[coll_idx];
                coll_ptr      <= PW'(rr_next(int'(coll_idx), NUM_ENGINES));
            end
        end
    end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench for pixel_dispatcher at W=8, H=2, N=3 with a behavioural
// 4-cycle engine pool that can be overridden by hand-driven done pulses.
module tb_pixel_dispatcher;
    import dispatcher_pkg::*;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int H  = 2;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int DW = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_start = 1'b0;
    logic pix_ready = 1'b1;
    logic frame_busy, frame_done, err_spurious;
    logic [N-1:0] eng_start, eng_done, eng_done_m, eng_done_f;
    logic [N-1:0][XW-1:0] eng_x;
    logic [N-1:0][YW-1:0] eng_y;
    logic [N-1:0][DW-1:0] eng_depth, eng_depth_m, eng_depth_f;
    logic eng_auto = 1'b1;
    logic sb_en = 1'b1;

    always #5 clk = ~clk;

    pixel_dispatcher_if #(.XW(XW), .YW(YW), .DEPTH_W(DW)) pif ();
    assign pif.pix_ready = pix_ready;
    assign eng_done  = eng_auto ? eng_done_m  : eng_done_f;
    assign eng_depth = eng_auto ? eng_depth_m : eng_depth_f;

    pixel_dispatcher #(
        .NUM_ENGINES(N), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H),
        .XW(XW), .YW(YW), .DEPTH_W(DW)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .frame_busy(frame_busy), .frame_done(frame_done),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
        .eng_done(eng_done), .eng_depth(eng_depth),
        .pix(pif), .err_spurious(err_spurious)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] fdep(input int x, input int y);
        return DW'((x * 7 + y * 50 + 3) % 1024);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Engine model: done pulse 4 cycles after the start pulse is seen.
    int cnt [N];
    initial begin
        eng_done_m  = '0;
        eng_depth_m = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                eng_done_m[i] = 1'b0;
                if (reset) cnt[i] = 0;
                else begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            eng_done_m[i]  = 1'b1;
                            eng_depth_m[i] = fdep(int'(eng_x[i]), int'(eng_y[i]));
                        end
                    end
                    if (eng_start[i]) cnt[i] = 4;
                end
            end
        end
    end

    // Monitor: handshakes, pulses and stability, sampled mid-cycle.
    int total = 0, bad_depth = 0, unstable = 0, done_cnt = 0, overlap = 0;
    int start_cnt = 0, pv_cnt = 0;
    int seen [W*H];
    logic pv_q = 1'b0, pr_q = 1'b0;
    logic [XW-1:0] px_q = '0;
    logic [YW-1:0] py_q = '0;
    logic [DW-1:0] pd_q = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (pif.pix_valid) pv_cnt++;
            if (frame_done) done_cnt++;
            if (frame_done && frame_busy) overlap++;
            for (int i = 0; i < N; i++) if (eng_start[i]) start_cnt++;
            if (pv_q && !pr_q && (!pif.pix_valid || pif.pix_x != px_q ||
                                  pif.pix_y != py_q || pif.pix_depth != pd_q)) unstable++;
            if (sb_en && pif.pix_valid && pix_ready) begin
                total++;
                if (pif.pix_x < W && pif.pix_y < H) seen[int'(pif.pix_y) * W + int'(pif.pix_x)]++;
                else bad_depth++;
                if (pif.pix_depth != fdep(int'(pif.pix_x), int'(pif.pix_y))) bad_depth++;
            end
            pv_q = pif.pix_valid; pr_q = pix_ready;
            px_q = pif.pix_x; py_q = pif.pix_y; pd_q = pif.pix_depth;
        end
    end

    function automatic int seen_all(input int k);
        for (int i = 0; i < W * H; i++) if (seen[i] != k) return 0;
        return 1;
    endfunction

    task automatic wait_done(input int prev, input int budget, input string tag);
        int c = 0;
        while (done_cnt == prev && c < budget) begin
            tick(1);
            c++;
        end
        chk(tag, 32'(done_cnt > prev), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int d, t, s, s2, p, c;

    initial begin
        eng_done_f = '0;
        eng_depth_f = '0;
        tick(3);
        chk("rst_busy", frame_busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_pix_valid", pif.pix_valid, 0);
        chk("rst_err", err_spurious, 0);
        reset = 1'b0;
        tick(2);

        // Spurious done in S_IDLE
        eng_auto = 1'b0;
        p = pv_cnt;
        eng_done_f = 3'b010;
        tick(1);
        eng_done_f = '0;
        chk("spur_set", err_spurious, 1);
        tick(5);
        chk("spur_sticky", err_spurious, 1);
        chk("spur_no_pix", pv_cnt - p, 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("spur_clear", err_spurious, 0);
        eng_auto = 1'b1;
        tick(1);

        // Fixed-latency frame, start latency
        d = done_cnt; t = total;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        chk("lat_k_start", eng_start, 0);
        chk("lat_busy", frame_busy, 1);
        tick(1);
        chk("lat_s0", eng_start, 3'b001);
        chk("lat_x0", eng_x[0], 0);
        chk("lat_y0", eng_y[0], 0);
        tick(1);
        chk("lat_s1", eng_start, 3'b010);
        chk("lat_x1", eng_x[1], 1);
        tick(1);
        chk("lat_s2", eng_start, 3'b100);
        chk("lat_x2", eng_x[2], 2);
        wait_done(d, 400, "f1_done");
        tick(5);
        chk("f1_count", total - t, 16);
        chk("f1_each_once", seen_all(1), 1);
        chk("f1_depth", bad_depth, 0);
        chk("f1_done_once", done_cnt - d, 1);
        chk("f1_busy_low", frame_busy, 0);

        // Backpressure
        reset = 1'b1; tick(1); reset = 1'b0; tick(1);
        d = done_cnt; t = total; s = start_cnt;
        pix_ready = 1'b0;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(12);
        s2 = start_cnt;
        tick(8);
        chk("bp_valid", pif.pix_valid, 1);
        chk("bp_x", pif.pix_x, 0);
        chk("bp_y", pif.pix_y, 0);
        chk("bp_depth", pif.pix_depth, fdep(0, 0));
        chk("bp_starts", start_cnt - s, 4);
        chk("bp_stall", start_cnt - s2, 0);
        chk("bp_no_accept", total - t, 0);
        pix_ready = 1'b1;
        wait_done(d, 400, "bp_done");
        tick(5);
        chk("bp_count", total - t, 16);
        chk("bp_each_once", seen_all(2), 1);
        chk("bp_depth_ok", bad_depth, 0);
        chk("bp_stable", unstable, 0);
        chk("bp_done_once", done_cnt - d, 1);

        // Simultaneous completion, depths 5/9/200
        reset = 1'b1; tick(1); reset = 1'b0; tick(1);
        sb_en = 1'b0; eng_auto = 1'b0;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(3);
        chk("sim_started", eng_start, 3'b100);
        eng_done_f = 3'b111;
        eng_depth_f[0] = 10'd5; eng_depth_f[1] = 10'd9; eng_depth_f[2] = 10'd200;
        tick(1);
        eng_done_f = '0;
        chk("sim_empty", pif.pix_valid, 0);
        tick(1);
        chk("sim_p0_valid", pif.pix_valid, 1);
        chk("sim_p0_depth", pif.pix_depth, 5);
        chk("sim_p0_x", pif.pix_x, 0);
        chk("sim_p0_nostart", eng_start, 0);
        tick(1);
        chk("sim_p1_depth", pif.pix_depth, 9);
        chk("sim_p1_x", pif.pix_x, 1);
        chk("sim_re0", eng_start, 3'b001);
        chk("sim_re0_x", eng_x[0], 3);
        tick(1);
        chk("sim_p2_depth", pif.pix_depth, 200);
        chk("sim_p2_x", pif.pix_x, 2);
        chk("sim_re1", eng_start, 3'b010);
        chk("sim_re1_x", eng_x[1], 4);
        tick(1);
        chk("sim_drained", pif.pix_valid, 0);
        chk("sim_re2", eng_start, 3'b100);
        chk("sim_re2_x", eng_x[2], 5);

        // Reset mid-frame (engines running)
        d = done_cnt;
        reset = 1'b1;
        #1;
        chk("rmf_start", eng_start, 0);
        chk("rmf_busy", frame_busy, 0);
        chk("rmf_x2", eng_x[2], 0);
        tick(3);
        reset = 1'b0; eng_auto = 1'b1; sb_en = 1'b1;
        tick(1);
        chk("rmf_no_done", done_cnt - d, 0);
        t = total;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        wait_done(d, 400, "rmf_done");
        tick(5);
        chk("rmf_count", total - t, 16);
        chk("rmf_each_once", seen_all(3), 1);
        chk("rmf_done_once", done_cnt - d, 1);

        // frame_start during S_DRAIN is ignored
        reset = 1'b1; tick(1); reset = 1'b0; tick(1);
        d = done_cnt; t = total; s = start_cnt;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        c = 0;
        while (start_cnt - s < 16 && c < 400) begin
            tick(1);
            c++;
        end
        chk("drn_reached", start_cnt - s, 16);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        chk("drn_busy", frame_busy, 1);
        wait_done(d, 400, "drn_done");
        tick(30);
        chk("drn_no_jobs", start_cnt - s, 16);
        chk("drn_done_once", done_cnt - d, 1);
        chk("drn_count", total - t, 16);
        chk("drn_each_once", seen_all(4), 1);
        chk("drn_busy_falls", overlap, 0);
        chk("drn_idle", frame_busy, 0);
        chk("all_depths", bad_depth, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
